// File: rtl/cpr_cart_mapper.sv
`default_nettype none
// ============================================================================
// Module   : cpr_cart_mapper
// Function : CPR (RIFF "AMS!") download parser to cartridge RAM, plus Z80
//            lower/upper ROM page mapper. CPR_CHECKSUM_EN adds a byte sum.
// Revision : 1.0
// ============================================================================
module cpr_cart_mapper #(
  parameter int NUM_PAGES     = 32,
  parameter int ADDR_W        = 19,
  parameter int DEFAULT_UPPER = 3,
  parameter int CPR_INDEX     = 5
) (
  input  logic                 clk_sys,
  input  logic                 reset,
  input  logic                 ioctl_download,
  input  logic [7:0]           ioctl_index,
  input  logic                 ioctl_wr,
  input  logic [7:0]           ioctl_dout,
  output logic                 dl_wr,
  output logic [ADDR_W-1:0]    dl_addr,
  output logic [7:0]           dl_data,
  output logic [NUM_PAGES-1:0] page_map,
  output logic                 cart_valid,
  output logic                 cart_err,
  output logic [15:0]          cpr_checksum,
  input  logic                 rom_sel_wr,
  input  logic [7:0]           rom_sel_data,
  input  logic [2:0]           lo_page,
  input  logic [15:0]          cpu_addr,
  input  logic                 cpu_rd,
  output logic [ADDR_W-1:0]    map_addr,
  output logic                 map_rd,
  output logic                 map_miss
);

  localparam int         PAGE_W = (NUM_PAGES > 1) ? $clog2(NUM_PAGES) : 1;
  localparam int         MAP_W  = (PAGE_W > 3) ? PAGE_W : 3;
  localparam int         MAP_SZ = 2 ** MAP_W;
  localparam logic [6:0] NP7    = 7'(NUM_PAGES);
  localparam logic [5:0] NP6    = 6'(NUM_PAGES);

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_HDR  = 3'd1,
    ST_CHDR = 3'd2,
    ST_DATA = 3'd3,
    ST_PAD  = 3'd4,
    ST_ERR  = 3'd5
  } state_t;

  state_t                state_q, state_d;
  logic [31:0]           cnt_q, cnt_d;
  logic [31:0]           id_q, id_d;
  logic [31:0]           size_q, size_d;
  logic                  is_page_q, is_page_d;
  logic [PAGE_W-1:0]     page_q, page_d;
  logic [NUM_PAGES-1:0]  page_map_q, page_map_d;
  logic                  cart_valid_q, cart_valid_d;
  logic                  cart_err_q, cart_err_d;
  logic                  dl_wr_q, dl_wr_d;
  logic [ADDR_W-1:0]     dl_addr_q, dl_addr_d;
  logic [7:0]            dl_data_q, dl_data_d;
  logic [PAGE_W-1:0]     upper_q, upper_d;
  logic [ADDR_W-1:0]     map_addr_q, map_addr_d;
  logic                  map_rd_q, map_rd_d;
  logic                  map_miss_q, map_miss_d;
  logic                  dl_prev_q, dl_prev_d;

  logic                  cpr_idx, dl_start, dl_end, byte_en;
  logic [6:0]            chunk_nn;
  logic                  chunk_is_page;
  logic [MAP_W-1:0]      map_page;
  logic [MAP_SZ-1:0]     map_present;
  logic                  unused_addr_bit;

  function automatic logic [7:0] sig_byte(input logic [3:0] idx);
    case (idx)
      4'd0:    sig_byte = 8'h52;
      4'd1:    sig_byte = 8'h49;
      4'd2:    sig_byte = 8'h46;
      4'd3:    sig_byte = 8'h46;
      4'd8:    sig_byte = 8'h41;
      4'd9:    sig_byte = 8'h4D;
      4'd10:   sig_byte = 8'h53;
      4'd11:   sig_byte = 8'h21;
      default: sig_byte = 8'h00;
    endcase
  endfunction

  function automatic logic is_digit(input logic [7:0] b);
    is_digit = (b >= 8'h30) && (b <= 8'h39);
  endfunction

  assign cpr_idx  = (ioctl_index == 8'(CPR_INDEX));
  assign dl_start = ioctl_download & ~dl_prev_q & cpr_idx;
  assign dl_end   = ~ioctl_download & dl_prev_q;
  assign byte_en  = ioctl_wr & ioctl_download & cpr_idx;

  // id_q holds the four id bytes, first byte in the top octet
  assign chunk_nn      = 7'(id_q[11:8]) * 7'd10 + 7'(id_q[3:0]);
  assign chunk_is_page = (id_q[31:16] == 16'h6362) && is_digit(id_q[15:8]) &&
                         is_digit(id_q[7:0]) && (chunk_nn < NP7);

  assign map_page        = cpu_addr[15] ? MAP_W'(upper_q) : MAP_W'(lo_page);
  assign map_present     = MAP_SZ'(page_map_q);
  assign unused_addr_bit = cpu_addr[14];

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    id_d         = id_q;
    size_d       = size_q;
    is_page_d    = is_page_q;
    page_d       = page_q;
    page_map_d   = page_map_q;
    cart_valid_d = cart_valid_q;
    cart_err_d   = cart_err_q;
    dl_wr_d      = 1'b0;
    dl_addr_d    = dl_addr_q;
    dl_data_d    = dl_data_q;
    upper_d      = upper_q;
    map_addr_d   = map_addr_q;
    map_rd_d     = 1'b0;
    map_miss_d   = map_miss_q;
    dl_prev_d    = ioctl_download;

    if (dl_start) begin
      state_d      = ST_HDR;
      cnt_d        = '0;
      page_map_d   = '0;
      cart_valid_d = 1'b0;
      cart_err_d   = 1'b0;
    end else if (dl_end && (state_q != ST_IDLE)) begin
      if (state_q != ST_ERR) begin
        if ((state_q == ST_CHDR) && (cnt_q == 32'd0) && (page_map_q != '0))
          cart_valid_d = 1'b1;
        else
          cart_err_d = 1'b1;
      end
      state_d = ST_IDLE;
    end else if (byte_en) begin
      case (state_q)
        ST_HDR: begin
          cnt_d = cnt_q + 32'd1;
          if ((cnt_q[3:2] != 2'b01) && (ioctl_dout != sig_byte(cnt_q[3:0]))) begin
            state_d    = ST_ERR;
            cart_err_d = 1'b1;
          end else if (cnt_q[3:0] == 4'd11) begin
            state_d = ST_CHDR;
            cnt_d   = '0;
          end
        end
        ST_CHDR: begin
          cnt_d = cnt_q + 32'd1;
          if (cnt_q[2] == 1'b0)
            id_d = {id_q[23:0], ioctl_dout};
          else
            size_d = {ioctl_dout, size_q[31:8]};
          if (cnt_q[2:0] == 3'd7) begin
            cnt_d     = '0;
            is_page_d = chunk_is_page;
            page_d    = chunk_nn[PAGE_W-1:0];
            state_d   = (size_d == 32'd0) ? ST_CHDR : ST_DATA;
          end
        end
        ST_DATA: begin
          // Only the first 16 KB of a page chunk lands in cartridge RAM
          if (is_page_q && (cnt_q < 32'd16384)) begin
            dl_wr_d   = 1'b1;
            dl_addr_d = ADDR_W'({page_q, cnt_q[13:0]});
            dl_data_d = ioctl_dout;
          end
          if (cnt_q == size_q - 32'd1) begin
            cnt_d = '0;
            if (is_page_q)
              page_map_d[page_q] = 1'b1;
            state_d = size_q[0] ? ST_PAD : ST_CHDR;
          end else begin
            cnt_d = cnt_q + 32'd1;
          end
        end
        ST_PAD: begin
          state_d = ST_CHDR;
          cnt_d   = '0;
        end
        default: ;
      endcase
    end

    if (rom_sel_wr) begin
      if ((rom_sel_data[7:5] == 3'b100) && ({1'b0, rom_sel_data[4:0]} < NP6))
        upper_d = rom_sel_data[PAGE_W-1:0];
      else
        upper_d = PAGE_W'(DEFAULT_UPPER);
    end

    if (cpu_rd) begin
      map_rd_d   = 1'b1;
      map_addr_d = ADDR_W'({map_page, cpu_addr[13:0]});
      map_miss_d = ~map_present[map_page];
    end
  end

  always_ff @(posedge clk_sys) begin
    if (reset) begin
      state_q      <= ST_IDLE;
      cnt_q        <= '0;
      id_q         <= '0;
      size_q       <= '0;
      is_page_q    <= 1'b0;
      page_q       <= '0;
      page_map_q   <= '0;
      cart_valid_q <= 1'b0;
      cart_err_q   <= 1'b0;
      dl_wr_q      <= 1'b0;
      dl_addr_q    <= '0;
      dl_data_q    <= '0;
      upper_q      <= PAGE_W'(DEFAULT_UPPER);
      map_addr_q   <= '0;
      map_rd_q     <= 1'b0;
      map_miss_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      id_q         <= id_d;
      size_q       <= size_d;
      is_page_q    <= is_page_d;
      page_q       <= page_d;
      page_map_q   <= page_map_d;
      cart_valid_q <= cart_valid_d;
      cart_err_q   <= cart_err_d;
      dl_wr_q      <= dl_wr_d;
      dl_addr_q    <= dl_addr_d;
      dl_data_q    <= dl_data_d;
      upper_q      <= upper_d;
      map_addr_q   <= map_addr_d;
      map_rd_q     <= map_rd_d;
      map_miss_q   <= map_miss_d;
    end
  end

  // Tracks the level through reset so a download still high after reset is not a new start
  always_ff @(posedge clk_sys) begin
    dl_prev_q <= dl_prev_d;
  end

`ifdef CPR_CHECKSUM_EN
  logic [15:0] csum_q, csum_d;

  always_comb begin
    csum_d = csum_q;
    if (dl_start)
      csum_d = '0;
    else if (dl_wr_d)
      csum_d = csum_q + {8'h00, dl_data_d};
  end

  always_ff @(posedge clk_sys) begin
    if (reset)
      csum_q <= '0;
    else
      csum_q <= csum_d;
  end

  assign cpr_checksum = csum_q;
`else
  assign cpr_checksum = 16'h0000;
`endif

  assign dl_wr      = dl_wr_q;
  assign dl_addr    = dl_addr_q;
  assign dl_data    = dl_data_q;
  assign page_map   = page_map_q;
  assign cart_valid = cart_valid_q;
  assign cart_err   = cart_err_q;
  assign map_addr   = map_addr_q;
  assign map_rd     = map_rd_q;
  assign map_miss   = map_miss_q;

endmodule
`default_nettype wire

// File: tb/tb_cpr_cart_mapper.sv
`default_nettype none
// Bench for cpr_cart_mapper: byte-walk CPR model feeding a write scoreboard, plus directed ROM map reads.
module tb_cpr_cart_mapper;
  localparam int NUM_PAGES = 32, ADDR_W = 19, DEFAULT_UPPER = 3, CPR_INDEX = 5;

  logic clk_sys = 1'b0, reset = 1'b1;
  logic ioctl_download = 1'b0, ioctl_wr = 1'b0;
  logic [7:0] ioctl_index = 8'd0, ioctl_dout = 8'd0;
  logic dl_wr, cart_valid, cart_err, map_rd, map_miss;
  logic [ADDR_W-1:0] dl_addr, map_addr;
  logic [7:0] dl_data;
  logic [NUM_PAGES-1:0] page_map;
  logic [15:0] cpr_checksum;
  logic rom_sel_wr = 1'b0, cpu_rd = 1'b0;
  logic [7:0] rom_sel_data = 8'd0;
  logic [2:0] lo_page = 3'd0;
  logic [15:0] cpu_addr = 16'd0;

  always #5 clk_sys = ~clk_sys;

  cpr_cart_mapper #(.NUM_PAGES(NUM_PAGES), .ADDR_W(ADDR_W), .DEFAULT_UPPER(DEFAULT_UPPER),
                    .CPR_INDEX(CPR_INDEX)) dut (
    .clk_sys(clk_sys), .reset(reset), .ioctl_download(ioctl_download), .ioctl_index(ioctl_index),
    .ioctl_wr(ioctl_wr), .ioctl_dout(ioctl_dout), .dl_wr(dl_wr), .dl_addr(dl_addr),
    .dl_data(dl_data), .page_map(page_map), .cart_valid(cart_valid), .cart_err(cart_err),
    .cpr_checksum(cpr_checksum), .rom_sel_wr(rom_sel_wr), .rom_sel_data(rom_sel_data),
    .lo_page(lo_page), .cpu_addr(cpu_addr), .cpu_rd(cpu_rd), .map_addr(map_addr),
    .map_rd(map_rd), .map_miss(map_miss));

  typedef struct packed { logic [ADDR_W-1:0] addr; logic [7:0] data; } wr_t;

  int errors = 0, checks = 0;
  wr_t exp_q[$];
  wr_t cmp_e;
  logic [7:0] img[$];
  logic [31:0] m_pm;
  logic m_valid, m_err;
  logic [15:0] m_sum;
  logic [4:0] m_upper;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
    end
  endtask

  // Scoreboard: every dl_wr pulse must match the next write the model predicted
  always @(negedge clk_sys) begin
    if (dl_wr === 1'b1) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL dl_wr_unexpected: got write addr=0x%0h data=0x%0h, want no write", dl_addr, dl_data);
      end else begin
        cmp_e = exp_q.pop_front();
        chk("dl_addr", 32'(dl_addr), 32'(cmp_e.addr));
        chk("dl_data", 32'(dl_data), 32'(cmp_e.data));
      end
    end
  end

  task automatic put_id(input logic [31:0] id);
    for (int i = 3; i >= 0; i--) img.push_back(id[8*i +: 8]);
  endtask

  task automatic put32le(input logic [31:0] v);
    for (int i = 0; i < 4; i++) img.push_back(v[8*i +: 8]);
  endtask

  task automatic put_hdr();
    put_id("RIFF"); put32le(32'h0000_1234); put_id("AMS!");
  endtask

  // Walks the first len bytes of img as a CPR file and records what the cartridge should see
  task automatic build_model(input int len);
    logic [7:0] sig [12];
    logic [31:0] id, size;
    int pos, nn;
    bit pg;
    wr_t w;
    sig = '{8'h52, 8'h49, 8'h46, 8'h46, 8'h00, 8'h00, 8'h00, 8'h00, 8'h41, 8'h4D, 8'h53, 8'h21};
    exp_q.delete();
    m_pm = '0; m_valid = 1'b0; m_err = 1'b0; m_sum = '0;
    if (len < 12) begin m_err = 1'b1; return; end
    for (int i = 0; i < 12; i++)
      if ((i < 4 || i >= 8) && img[i] != sig[i]) begin m_err = 1'b1; return; end
    pos = 12;
    forever begin
      if (pos == len) begin
        if (m_pm != 0) m_valid = 1'b1; else m_err = 1'b1;
        return;
      end
      if (len - pos < 8) begin m_err = 1'b1; return; end
      id   = {img[pos], img[pos+1], img[pos+2], img[pos+3]};
      size = {img[pos+7], img[pos+6], img[pos+5], img[pos+4]};
      pos += 8;
      nn = (int'(id[15:8]) - 48) * 10 + (int'(id[7:0]) - 48);
      pg = (id[31:16] == 16'h6362) && id[15:8] >= 8'h30 && id[15:8] <= 8'h39 &&
           id[7:0] >= 8'h30 && id[7:0] <= 8'h39 && nn < NUM_PAGES;
      for (int k = 0; k < int'(size); k++) begin
        if (pos >= len) begin m_err = 1'b1; return; end
        if (pg && k < 16384) begin
          w.addr = ADDR_W'(nn * 16384 + k);
          w.data = img[pos];
          exp_q.push_back(w);
          m_sum = m_sum + 16'(img[pos]);
        end
        pos++;
      end
      if (pg && size != 0) m_pm[nn] = 1'b1;
      if (size[0]) begin
        if (pos >= len) begin m_err = 1'b1; return; end
        pos++;
      end
    end
  endtask

  task automatic start_dl();
    ioctl_index = 8'(CPR_INDEX);
    ioctl_download = 1'b1;
    repeat (2) @(negedge clk_sys);
  endtask

  task automatic send_range(input int from, input int to);
    for (int i = from; i < to; i++) begin
      ioctl_wr = 1'b1; ioctl_dout = img[i];
      @(negedge clk_sys);
    end
    ioctl_wr = 1'b0;
  endtask

  task automatic end_dl();
    ioctl_download = 1'b0;
    repeat (3) @(negedge clk_sys);
  endtask

  task automatic check_result(input string name);
    chk({name, "_page_map"}, 32'(page_map), m_pm);
    chk({name, "_cart_valid"}, 32'(cart_valid), 32'(m_valid));
    chk({name, "_cart_err"}, 32'(cart_err), 32'(m_err));
`ifdef CPR_CHECKSUM_EN
    chk({name, "_checksum"}, 32'(cpr_checksum), 32'(m_sum));
`else
    chk({name, "_checksum"}, 32'(cpr_checksum), 32'h0);
`endif
    chk({name, "_writes_left"}, 32'(exp_q.size()), 32'd0);
  endtask

  task automatic run_image(input string name);
    start_dl();
    send_range(0, img.size());
    end_dl();
    check_result(name);
  endtask

  function automatic logic [4:0] sel_rule(input logic [7:0] v);
    if (v[7:5] == 3'b100 && int'(v[4:0]) < NUM_PAGES) return v[4:0];
    return 5'(DEFAULT_UPPER);
  endfunction

  task automatic do_sel(input logic [7:0] v);
    rom_sel_wr = 1'b1; rom_sel_data = v;
    @(negedge clk_sys);
    rom_sel_wr = 1'b0;
    m_upper = sel_rule(v);
  endtask

  task automatic do_read(input string name, input logic [15:0] addr, input logic [2:0] lo,
                         input bit sel_en, input logic [7:0] sel_val, input logic [31:0] lit);
    int page;
    logic [31:0] ea;
    logic em;
    page = addr[15] ? int'(m_upper) : int'(lo);
    ea = 32'(page * 16384 + int'(addr[13:0]));
    em = (page >= NUM_PAGES) ? 1'b1 : ~m_pm[page];
    chk({"pin_", name}, ea, lit);
    cpu_addr = addr; lo_page = lo; cpu_rd = 1'b1;
    rom_sel_wr = sel_en; rom_sel_data = sel_val;
    @(negedge clk_sys);
    cpu_rd = 1'b0; rom_sel_wr = 1'b0;
    if (sel_en) m_upper = sel_rule(sel_val);
    chk({name, "_map_rd"}, 32'(map_rd), 32'd1);
    chk({name, "_map_addr"}, 32'(map_addr), ea);
    chk({name, "_map_miss"}, 32'(map_miss), 32'(em));
    @(negedge clk_sys);
    chk({name, "_map_rd_pulse"}, 32'(map_rd), 32'd0);
    chk({name, "_map_addr_hold"}, 32'(map_addr), ea);
  endtask

  task automatic img_small();
    img.delete();
    put_hdr();
    put_id("brcs"); put32le(32'd4);
    for (int i = 1; i <= 4; i++) img.push_back(8'(i));
    put_id("cb00"); put32le(32'd1); img.push_back(8'h5A);
    img.push_back(8'h00);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    m_upper = 5'(DEFAULT_UPPER);
    m_pm = '0;
    repeat (4) @(negedge clk_sys);
    chk("rst_dl_wr", 32'(dl_wr), 0);
    chk("rst_dl_addr", 32'(dl_addr), 0);
    chk("rst_dl_data", 32'(dl_data), 0);
    chk("rst_page_map", 32'(page_map), 0);
    chk("rst_cart_valid", 32'(cart_valid), 0);
    chk("rst_cart_err", 32'(cart_err), 0);
    chk("rst_checksum", 32'(cpr_checksum), 0);
    chk("rst_map_addr", 32'(map_addr), 0);
    chk("rst_map_rd", 32'(map_rd), 0);
    chk("rst_map_miss", 32'(map_miss), 0);
    reset = 1'b0;
    @(negedge clk_sys);
    do_read("rst_upper", 16'h8000, 3'd0, 1'b0, 8'h00, 32'h0C000);

    // Two full pages, data = k[7:0]
    img.delete();
    put_hdr();
    put_id("cb00"); put32le(32'd16384);
    for (int k = 0; k < 16384; k++) img.push_back(8'(k));
    put_id("cb01"); put32le(32'd16384);
    for (int k = 0; k < 16384; k++) img.push_back(8'(k));
    build_model(img.size());
    chk("pin_t1_count", 32'(exp_q.size()), 32'd32768);
    chk("pin_t1_first", 32'(exp_q[0]), 32'h0000_0000);
    chk("pin_t1_last", 32'(exp_q[32767]), 32'h07FFF_FF);
    chk("pin_t1_pm", m_pm, 32'h3);
    run_image("t1");

    // Bad signature at byte 8
    img.delete();
    put_id("RIFF"); put32le(32'd0); put_id("XMS!");
    put_id("cb00"); put32le(32'd1); img.push_back(8'h55); img.push_back(8'h00);
    build_model(img.size());
    chk("pin_t2_err", 32'(m_err), 32'd1);
    chk("pin_t2_count", 32'(exp_q.size()), 32'd0);
    run_image("t2");

    // Odd-size chunk with pad, then a second page
    img.delete();
    put_hdr();
    put_id("cb05"); put32le(32'd3);
    img.push_back(8'h11); img.push_back(8'h22); img.push_back(8'h33); img.push_back(8'hEE);
    put_id("cb02"); put32le(32'd2);
    img.push_back(8'hAA); img.push_back(8'hBB);
    build_model(img.size());
    chk("pin_t3_count", 32'(exp_q.size()), 32'd5);
    chk("pin_t3_w0", 32'(exp_q[0]), 32'h14000_11);
    chk("pin_t3_w3", 32'(exp_q[3]), 32'h08000_AA);
    chk("pin_t3_pm", m_pm, 32'h24);
    chk("pin_t3_sum", 32'(m_sum), 32'h01CB);
    run_image("t3");

    // Non-page chunk skipped
    img_small();
    build_model(img.size());
    chk("pin_t4_count", 32'(exp_q.size()), 32'd1);
    chk("pin_t4_valid", 32'(m_valid), 32'd1);
    run_image("t4");

    // Upper/lower ROM mapping with page_map = 0x1
    do_sel(8'h85);
    do_read("m_c123", 16'hC123, 3'd0, 1'b0, 8'h00, 32'h14123);
    do_sel(8'h07);
    do_read("m_c000", 16'hC000, 3'd0, 1'b0, 8'h00, 32'h0C000);
    do_read("m_lo0", 16'h1234, 3'd0, 1'b0, 8'h00, 32'h01234);
    do_sel(8'h9F);
    do_read("m_p31", 16'hFFFF, 3'd0, 1'b0, 8'h00, 32'h7FFFF);
    do_sel(8'hA0);
    do_read("m_dflt", 16'h8001, 3'd0, 1'b0, 8'h00, 32'h0C001);
    do_read("m_same", 16'hC000, 3'd0, 1'b1, 8'h81, 32'h0C000);
    do_read("m_new", 16'hC000, 3'd0, 1'b0, 8'h00, 32'h04000);
    do_read("m_lo5", 16'h0010, 3'd5, 1'b0, 8'h00, 32'h14010);

    // Reset 5000 bytes into a valid download
    img.delete();
    put_hdr();
    put_id("cb00"); put32le(32'd16384);
    for (int k = 0; k < 16384; k++) img.push_back(8'(k) ^ 8'h3C);
    build_model(5000);
    chk("pin_t5_count", 32'(exp_q.size()), 32'd4980);
    start_dl();
    send_range(0, 5000);
    reset = 1'b1;
    repeat (2) @(negedge clk_sys);
    chk("t5_rst_dl_wr", 32'(dl_wr), 0);
    chk("t5_rst_dl_addr", 32'(dl_addr), 0);
    chk("t5_rst_dl_data", 32'(dl_data), 0);
    chk("t5_rst_page_map", 32'(page_map), 0);
    chk("t5_rst_cart_valid", 32'(cart_valid), 0);
    chk("t5_rst_cart_err", 32'(cart_err), 0);
    chk("t5_rst_checksum", 32'(cpr_checksum), 0);
    chk("t5_rst_map_addr", 32'(map_addr), 0);
    chk("t5_rst_map_miss", 32'(map_miss), 0);
    reset = 1'b0;
    m_upper = 5'(DEFAULT_UPPER);
    @(negedge clk_sys);
    send_range(5000, img.size());
    end_dl();
    m_pm = '0; m_valid = 1'b0; m_err = 1'b0; m_sum = '0;
    check_result("t5_after");
    do_read("t5_upper", 16'hC000, 3'd0, 1'b0, 8'h00, 32'h0C000);
    img_small();
    build_model(img.size());
    run_image("t5_fresh");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
